hazard_scoreboard: RTL and testbench
====================================

Name: hazard_scoreboard

Overview:
- Parametrised successor to the combinational operand-hazard decoder.
- Tracks in-flight register writes in a per-register scoreboard and, at decode, decides per source operand: stall, forward (and from which stage), or read the register file.
- Supports multi-cycle latency classes (ALU/load/mul), WAW protection and branch flush.
- Sits between the decode stage and the operand muxes and pipeline-enable logic.

Parameters:
- NREG, 4: architectural registers; index width RW = $clog2(NREG).
- PIPE_DEPTH, 3: stages after decode before writeback.
- ALU_LAT, 1: cycles after issue until an ALU result is forwardable.
- LOAD_LAT, 2: same, for loads.
- MUL_LAT, 3: same, for multiplies. All latencies must satisfy 1..PIPE_DEPTH; this is checked at elaboration.
- FLUSH_AGE, 1: entries with age <= FLUSH_AGE are killed by flush.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- id_valid  in  1  valid instruction in decode.
- id_use_a  in  1  operand A reads a register.
- id_use_b  in  1  operand B reads a register.
- id_src_a  in  RW  source register A.
- id_src_b  in  RW  source register B.
- id_wr_en  in  1  instruction writes a register.
- id_dst  in  RW  destination register.
- id_lat_cls  in  2  latency class: 0 ALU, 1 LOAD, 2 MUL, 3 reserved (treated as ALU).
- flush  in  1  branch redirect.
- stall  out  1  hold decode/fetch, insert bubble.
- fwd_sel_a  out  FW  operand A source: 0 = register file, k = stage k; FW = $clog2(PIPE_DEPTH+1).
- fwd_sel_b  out  FW  same, for operand B.
- busy_vec  out  NREG  pending-write bit per register.

Behaviour:
- Entry per register: busy, age (1..PIPE_DEPTH), cnt (cycles until forwardable).
- Reset:
  - All entries are cleared on reset.
  - Because outputs are combinational from entries and inputs, after reset stall=0, fwd_sel_a=fwd_sel_b=0 and busy_vec=0.
- Issue:
  - Condition: id_valid & id_wr_en & !stall & !flush.
  - Next cycle, entry[id_dst] becomes busy=1, age=1, cnt=lat-1.
  - A newer issue to the same register overwrites the older entry.
- Ageing: every cycle, each busy entry not overwritten does:
  - age++ and cnt = max(cnt-1, 0);
  - when age==PIPE_DEPTH it clears instead, because writeback is done and the register file now holds the value.
- RAW, for each used source s with entry[s] busy:
  - cnt>0 -> raise stall;
  - cnt==0 -> fwd_sel = age.
  - If the source is not used, r0 semantics do not apply; the entry is simply ignored and fwd_sel=0.
- WAW:
  - If id_wr_en and entry[id_dst] is busy with cnt >= new lat, raise stall.
  - This prevents a short-latency write completing before an older long one.
- stall gating:
  - stall is only asserted while id_valid=1.
  - While stall=1 no issue occurs; existing entries keep ageing, since bubbles flow on.
- Flush:
  - Entries with age <= FLUSH_AGE clear next cycle.
  - A same-cycle issue is suppressed.
  - Flush takes priority over issue, and ageing of surviving entries continues.
- Simultaneous events:
  - When an entry is clearing at age==PIPE_DEPTH in the same cycle a new issue targets that register, the new issue wins.
  - When a source reads a register whose entry is at age==PIPE_DEPTH, fwd_sel = PIPE_DEPTH.
- Mid-operation reset clears all in-flight state unconditionally.
- Both operands may forward from different stages in the same cycle.
- When src_a==src_b, both select the same value.

Optional Feature:
- Macro: HAZARD_FWD_EN.
- Defined: forwarding is active as described above.
- Undefined:
  - Any used source with a busy entry stalls until that entry clears.
  - fwd_sel_a and fwd_sel_b are tied to 0.
  - WAW rule unchanged.
  - Intended for a forwarding-free, area-reduced build.

Decomposition:
- Package hazard_pkg holds:
  - latency class encoding LAT_ALU=0, LAT_LOAD=1, LAT_MUL=2;
  - FWD_RF=0 constant;
  - function lat_of(cls), which maps class to latency parameter.
- Sub-module hazard_sb_entry: one register's busy/age/cnt state with issue, flush and ageing inputs, generated NREG times.
- Top level contains the RAW/WAW comparison and the output muxing.

Test Plan (defaults: NREG=4, PIPE_DEPTH=3):
- Back-to-back ALU:
  - Stimulus: ALU write R1 at cycle 0; cycle 1 reads R1 on A.
  - Required: stall=0, fwd_sel_a=1.
  - Cycle 2 read gives fwd_sel_a=2; cycle 4 read gives fwd_sel_a=0 and busy_vec=0000.
- Load-use:
  - Stimulus: LOAD R2 at cycle 0; cycle 1 reads R2 on B.
  - Required: stall=1 in cycle 1; cycle 2 gives stall=0, fwd_sel_b=2.
- MUL:
  - Stimulus: MUL R3 at cycle 0; consumer on A and B from cycle 1.
  - Required: stall=1 for cycles 1-2; cycle 3 gives fwd_sel_a=fwd_sel_b=3.
  - With HAZARD_FWD_EN undefined: stall for cycles 1-3, then fwd_sel=0 at cycle 4.
- WAW:
  - Stimulus: MUL R1 at cycle 0, then ALU write R1 at cycle 1.
  - Required: stall=1 in cycle 1 (cnt 2 >= 1), issue released when cnt < 1.
  - Afterwards busy_vec[1]=1 carries the ALU entry's age/cnt.
- Flush:
  - Stimulus: ALU R0 at cycle 0; flush=1 in cycle 1 together with a valid ALU write of R2.
  - Required: R0 entry cleared and R2 not issued; busy_vec=0000 at cycle 2.
- Reset mid-flight:
  - Stimulus: LOAD R3 issued, then rst=1 one cycle later.
  - Required: busy_vec=0000, stall=0 and fwd_sel=0 on the following cycle.

Source files
------------

// File: rtl/hazard_pkg.sv
// +--------------------------------------------------------------------------+
// | hazard_pkg : shared encodings and helpers for the hazard scoreboard       |
// | Revision   : 1.0                                                          |
// +--------------------------------------------------------------------------+
`default_nettype none

package hazard_pkg;

    typedef enum logic [1:0] {
        LAT_ALU  = 2'd0,
        LAT_LOAD = 2'd1,
        LAT_MUL  = 2'd2,
        LAT_RSVD = 2'd3
    } lat_cls_e;

    localparam int FWD_RF = 0;

    // Reserved class falls back to ALU timing.
    function automatic int lat_of(input logic [1:0] cls,
                                  input int alu_lat,
                                  input int load_lat,
                                  input int mul_lat);
        case (cls)
            LAT_LOAD: return load_lat;
            LAT_MUL:  return mul_lat;
            default:  return alu_lat;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/hazard_sb_entry.sv
// +--------------------------------------------------------------------------+
// | hazard_sb_entry : busy/age/cnt tracking for one architectural register    |
// | Revision        : 1.0                                                     |
// +--------------------------------------------------------------------------+
`default_nettype none

module hazard_sb_entry #(
    parameter int PIPE_DEPTH = 3,
    parameter int FLUSH_AGE  = 1,
    parameter int FW         = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          issue_i,
    input  logic [FW-1:0] issue_cnt_i,
    input  logic          flush_i,
    output logic          busy_o,
    output logic [FW-1:0] age_o,
    output logic [FW-1:0] cnt_o
);

    localparam logic [FW-1:0] c_LAST_AGE = FW'(PIPE_DEPTH);

    logic          busy_q, busy_d;
    logic [FW-1:0] age_q,  age_d;
    logic [FW-1:0] cnt_q,  cnt_d;

    // Issue beats both flush-kill and writeback retirement of the old entry.
    always_comb begin
        busy_d = busy_q;
        age_d  = age_q;
        cnt_d  = cnt_q;
        if (issue_i) begin
            busy_d = 1'b1;
            age_d  = FW'(1);
            cnt_d  = issue_cnt_i;
        end else if (busy_q) begin
            if ((flush_i && (int'(age_q) <= FLUSH_AGE)) || (age_q == c_LAST_AGE)) begin
                busy_d = 1'b0;
                age_d  = '0;
                cnt_d  = '0;
            end else begin
                age_d = age_q + FW'(1);
                cnt_d = (cnt_q == '0) ? '0 : cnt_q - FW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q <= 1'b0;
            age_q  <= '0;
            cnt_q  <= '0;
        end else begin
            busy_q <= busy_d;
            age_q  <= age_d;
            cnt_q  <= cnt_d;
        end
    end

    assign busy_o = busy_q;
    assign age_o  = age_q;
    assign cnt_o  = cnt_q;

endmodule

`default_nettype wire

// File: rtl/hazard_scoreboard.sv
// +--------------------------------------------------------------------------+
// | hazard_scoreboard : per-register write scoreboard with RAW/WAW decode     |
// | Optional macro HAZARD_FWD_EN enables operand forwarding.                  |
// | Revision          : 1.0                                                   |
// +--------------------------------------------------------------------------+
`default_nettype none

module hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter int NREG       = 4,
    parameter int PIPE_DEPTH = 3,
    parameter int ALU_LAT    = 1,
    parameter int LOAD_LAT   = 2,
    parameter int MUL_LAT    = 3,
    parameter int FLUSH_AGE  = 1,
    localparam int RW        = $clog2(NREG),
    localparam int FW        = $clog2(PIPE_DEPTH + 1)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            id_valid,
    input  logic            id_use_a,
    input  logic            id_use_b,
    input  logic [RW-1:0]   id_src_a,
    input  logic [RW-1:0]   id_src_b,
    input  logic            id_wr_en,
    input  logic [RW-1:0]   id_dst,
    input  logic [1:0]      id_lat_cls,
    input  logic            flush,
    output logic            stall,
    output logic [FW-1:0]   fwd_sel_a,
    output logic [FW-1:0]   fwd_sel_b,
    output logic [NREG-1:0] busy_vec
);

    if (ALU_LAT < 1 || ALU_LAT > PIPE_DEPTH ||
        LOAD_LAT < 1 || LOAD_LAT > PIPE_DEPTH ||
        MUL_LAT < 1 || MUL_LAT > PIPE_DEPTH) begin : g_bad_lat
        $error("hazard_scoreboard: latencies must lie in 1..PIPE_DEPTH");
    end

    logic [NREG-1:0] w_busy;
    logic [FW-1:0]   w_age [NREG];
    logic [FW-1:0]   w_cnt [NREG];
    logic [FW-1:0]   w_lat;
    logic [FW-1:0]   w_issue_cnt;
    logic            w_issue;

    assign w_lat       = FW'(lat_of(id_lat_cls, ALU_LAT, LOAD_LAT, MUL_LAT));
    assign w_issue_cnt = w_lat - FW'(1);
    assign w_issue     = id_valid & id_wr_en & ~stall & ~flush;

    for (genvar i = 0; i < NREG; i++) begin : g_entry
        hazard_sb_entry #(
            .PIPE_DEPTH (PIPE_DEPTH),
            .FLUSH_AGE  (FLUSH_AGE),
            .FW         (FW)
        ) u_entry (
            .clk         (clk),
            .rst         (rst),
            .issue_i     (w_issue && (id_dst == RW'(i))),
            .issue_cnt_i (w_issue_cnt),
            .flush_i     (flush),
            .busy_o      (w_busy[i]),
            .age_o       (w_age[i]),
            .cnt_o       (w_cnt[i])
        );
    end

    logic          w_raw_a, w_raw_b, w_waw;
    logic [FW-1:0] w_sel_a, w_sel_b;

    always_comb begin
        w_raw_a = 1'b0;
        w_raw_b = 1'b0;
        w_sel_a = FW'(FWD_RF);
        w_sel_b = FW'(FWD_RF);
`ifdef HAZARD_FWD_EN
        if (id_use_a && w_busy[id_src_a]) begin
            if (w_cnt[id_src_a] != '0) w_raw_a = 1'b1;
            else                       w_sel_a = w_age[id_src_a];
        end
        if (id_use_b && w_busy[id_src_b]) begin
            if (w_cnt[id_src_b] != '0) w_raw_b = 1'b1;
            else                       w_sel_b = w_age[id_src_b];
        end
`else
        w_raw_a = id_use_a && w_busy[id_src_a];
        w_raw_b = id_use_b && w_busy[id_src_b];
`endif
        // A shorter write must not retire ahead of an older, longer one.
        w_waw = id_wr_en && w_busy[id_dst] && (w_cnt[id_dst] >= w_lat);
    end

`ifndef HAZARD_FWD_EN
    logic [NREG*FW-1:0] w_unused_age;
    for (genvar j = 0; j < NREG; j++) begin : g_unused_age
        assign w_unused_age[j*FW +: FW] = w_age[j];
    end
`endif

    assign stall     = id_valid & (w_raw_a | w_raw_b | w_waw);
    assign fwd_sel_a = w_sel_a;
    assign fwd_sel_b = w_sel_b;
    assign busy_vec  = w_busy;

endmodule

`default_nettype wire

// File: tb/tb_hazard_scoreboard.sv
// +--------------------------------------------------------------------------+
// | tb_hazard_scoreboard : directed and random checks against a timestamp     |
// | model of in-flight writes.                                                |
// | Revision             : 1.0                                                |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_hazard_scoreboard;

    localparam int NREG      = 4;
    localparam int PD        = 3;
    localparam int FLUSH_AGE = 1;
    localparam int RW        = 2;
    localparam int FW        = 2;

    logic            clk = 1'b0;
    logic            rst;
    logic            id_valid, id_use_a, id_use_b, id_wr_en, flush;
    logic [RW-1:0]   id_src_a, id_src_b, id_dst;
    logic [1:0]      id_lat_cls;
    logic            stall;
    logic [FW-1:0]   fwd_sel_a, fwd_sel_b;
    logic [NREG-1:0] busy_vec;

    always #5 clk = ~clk;

    hazard_scoreboard dut (
        .clk        (clk),
        .rst        (rst),
        .id_valid   (id_valid),
        .id_use_a   (id_use_a),
        .id_use_b   (id_use_b),
        .id_src_a   (id_src_a),
        .id_src_b   (id_src_b),
        .id_wr_en   (id_wr_en),
        .id_dst     (id_dst),
        .id_lat_cls (id_lat_cls),
        .flush      (flush),
        .stall      (stall),
        .fwd_sel_a  (fwd_sel_a),
        .fwd_sel_b  (fwd_sel_b),
        .busy_vec   (busy_vec)
    );

    // Model: each register remembers the cycle its latest write issued and its latency.
    bit m_valid [NREG];
    int m_t     [NREG];
    int m_lat   [NREG];
    int now;
    int lat_tab [4] = '{1, 2, 3, 1};
    int exp_stall;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic bit m_busy(input int r);
        return m_valid[r] && ((now - m_t[r]) <= PD);
    endfunction

    function automatic int m_cnt(input int r);
        int left;
        left = m_lat[r] - (now - m_t[r]);
        return (left > 0) ? left : 0;
    endfunction

    task automatic operand(input bit use_s, input int src, output bit raw, output int sel);
        raw = 0;
        sel = 0;
        if (use_s && m_busy(src)) begin
`ifdef HAZARD_FWD_EN
            if (m_cnt(src) > 0) raw = 1;
            else                sel = now - m_t[src];
`else
            raw = 1;
`endif
        end
    endtask

    task automatic cycle(input bit v, input bit ua, input bit ub, input int sa, input int sb,
                         input bit wr, input int dst, input int cls, input bit fl,
                         input bit rs, input bit chk_en);
        bit raw_a, raw_b, waw;
        int sel_a, sel_b, e_busy;
        @(negedge clk);
        id_valid = v;  id_use_a = ua; id_use_b = ub;
        id_src_a = RW'(sa); id_src_b = RW'(sb);
        id_wr_en = wr; id_dst = RW'(dst); id_lat_cls = 2'(cls);
        flush = fl; rst = rs;
        #1;
        operand(ua, sa, raw_a, sel_a);
        operand(ub, sb, raw_b, sel_b);
        waw = wr && m_busy(dst) && (m_cnt(dst) >= lat_tab[cls]);
        exp_stall = (v && (raw_a || raw_b || waw)) ? 1 : 0;
        e_busy = 0;
        for (int r = 0; r < NREG; r++) if (m_busy(r)) e_busy |= (1 << r);
        if (chk_en) begin
            chk("stall", int'(stall), exp_stall);
            chk("fwd_sel_a", int'(fwd_sel_a), sel_a);
            chk("fwd_sel_b", int'(fwd_sel_b), sel_b);
            chk("busy_vec", int'(busy_vec), e_busy);
        end
        if (rs) begin
            for (int r = 0; r < NREG; r++) m_valid[r] = 0;
        end else begin
            if (fl) begin
                for (int r = 0; r < NREG; r++)
                    if (m_busy(r) && (now - m_t[r]) <= FLUSH_AGE) m_valid[r] = 0;
            end else if (v && wr && exp_stall == 0) begin
                m_valid[dst] = 1;
                m_t[dst]     = now;
                m_lat[dst]   = lat_tab[cls];
            end
        end
        now++;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    endtask

    int st [5];
    int fa [5];
    int fb [5];
`ifdef HAZARD_FWD_EN
    int mul_st [5] = '{0, 1, 1, 0, 0};
    int mul_fw [5] = '{0, 0, 0, 3, 0};
`else
    int mul_st [5] = '{0, 1, 1, 1, 0};
    int mul_fw [5] = '{0, 0, 0, 0, 0};
`endif
    int rel;

    initial begin
        now = 0;
        for (int r = 0; r < NREG; r++) begin m_valid[r] = 0; m_t[r] = 0; m_lat[r] = 1; end
        rst = 1'b1; id_valid = 0; id_use_a = 0; id_use_b = 0; id_wr_en = 0; flush = 0;
        id_src_a = '0; id_src_b = '0; id_dst = '0; id_lat_cls = '0;

        cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        idle(1);
        chk("rst_stall", int'(stall), 0);
        chk("rst_fwd_a", int'(fwd_sel_a), 0);
        chk("rst_fwd_b", int'(fwd_sel_b), 0);
        chk("rst_busy", int'(busy_vec), 0);

        // Back-to-back ALU into R1, then reads on A in later cycles.
        cycle(1, 0, 0, 0, 0, 1, 1, 0, 0, 0, 1);
        for (int k = 1; k <= 4; k++) cycle(1, 1, 0, 1, 0, 0, 0, 0, 0, 0, 1);
        chk("alu_busy_c4", int'(busy_vec), 0);
        idle(2);

        // Load-use on B.
        cycle(1, 0, 0, 0, 0, 1, 2, 1, 0, 0, 1);
        for (int k = 1; k <= 3; k++) cycle(1, 0, 1, 0, 2, 0, 0, 0, 0, 0, 1);
        idle(2);

        // MUL into R3, consumer on both operands.
        cycle(1, 0, 0, 0, 0, 1, 3, 2, 0, 0, 1);
        for (int k = 1; k <= 4; k++) begin
            cycle(1, 1, 1, 3, 3, 0, 0, 0, 0, 0, 1);
            st[k] = int'(stall); fa[k] = int'(fwd_sel_a); fb[k] = int'(fwd_sel_b);
        end
        for (int k = 1; k <= 4; k++) begin
            chk($sformatf("mul_stall_c%0d", k), st[k], mul_st[k]);
            chk($sformatf("mul_fwd_a_c%0d", k), fa[k], mul_fw[k]);
            chk($sformatf("mul_fwd_b_c%0d", k), fb[k], mul_fw[k]);
        end
        idle(2);

        // WAW: MUL R1 then an ALU write of R1 held until it may issue.
        cycle(1, 0, 0, 0, 0, 1, 1, 2, 0, 0, 1);
        rel = 0;
        for (int k = 1; k <= 6 && rel == 0; k++) begin
            cycle(1, 0, 0, 0, 0, 1, 1, 0, 0, 0, 1);
            if (stall == 1'b0) rel = k;
        end
        chk("waw_release", rel, 3);
        idle(1);
        chk("waw_busy1", int'(busy_vec[1]), 1);
        idle(4);

        // Flush kills the young ALU entry and suppresses the same-cycle issue.
        cycle(1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1);
        cycle(1, 0, 0, 0, 0, 1, 2, 0, 1, 0, 1);
        idle(1);
        chk("flush_busy", int'(busy_vec), 0);
        idle(2);

        // Reset while a load is in flight.
        cycle(1, 0, 0, 0, 0, 1, 3, 1, 0, 0, 1);
        cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
        cycle(1, 1, 0, 3, 0, 0, 0, 0, 0, 0, 1);
        chk("rstmid_busy", int'(busy_vec), 0);
        chk("rstmid_stall", int'(stall), 0);
        chk("rstmid_fwd_a", int'(fwd_sel_a), 0);

        for (int k = 0; k < 3000; k++) begin
            cycle(($urandom % 4) != 0, 1'($urandom), 1'($urandom),
                  int'($urandom_range(0, NREG - 1)), int'($urandom_range(0, NREG - 1)),
                  1'($urandom), int'($urandom_range(0, NREG - 1)), int'($urandom_range(0, 3)),
                  ($urandom % 8) == 0, ($urandom % 97) == 0, 1);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
